// File: rtl/conv_layer_seq_if.sv
// Handshake and bus bundle between conv_layer_seq, its parameter/pixel sources and one conv instance.
// master = sequencer side, slave = environment (sources, conv, downstream fifo).
interface conv_layer_seq_if #(
    parameter int IN_CHANNEL = 2
);
    logic [31:0]             w_data;
    logic                    w_valid;
    logic                    w_ready;
    logic [31:0]             weight_wr_data;
    logic [31:0]             weight_wr_addr;
    logic                    weight_wr_en;
    logic [8*IN_CHANNEL-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [8*IN_CHANNEL-1:0] conv_i_data;
    logic                    conv_i_valid;
    logic                    fifo_almost_full;
    logic                    conv_o_valid;

    modport master (
        input  w_data, w_valid, s_data, s_valid, fifo_almost_full, conv_o_valid,
        output w_ready, weight_wr_data, weight_wr_addr, weight_wr_en,
               s_ready, conv_i_data, conv_i_valid
    );

    modport slave (
        output w_data, w_valid, s_data, s_valid, fifo_almost_full, conv_o_valid,
        input  w_ready, weight_wr_data, weight_wr_addr, weight_wr_en,
               s_ready, conv_i_data, conv_i_valid
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Per-layer sequencer: replays a packed parameter stream onto the conv weight port, then gates one
// frame of pixels into conv and counts its outputs. Drain watchdog enabled by CONV_LAYER_SEQ_WDOG_EN.
module conv_layer_seq #(
    parameter int IN_WIDTH         = 8,
    parameter int IN_HEIGHT        = 8,
    parameter int OUT_WIDTH        = 8,
    parameter int OUT_HEIGHT       = 8,
    parameter int KERNEL_0         = 3,
    parameter int KERNEL_1         = 3,
    parameter int IN_CHANNEL       = 2,
    parameter int OUT_CHANNEL      = 2,
    parameter int KERNEL_BASE_ADDR = 0,
    parameter int WDOG_CYCLES      = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    conv_layer_seq_if.master bus
);
    localparam int NK         = KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL;
    localparam int BIAS_BASE  = KERNEL_BASE_ADDR + NK;
    localparam int COEFF_ADDR = BIAS_BASE + OUT_CHANNEL;
    localparam int SCALE_ADDR = COEFF_ADDR + 1;
    localparam int NPIX       = IN_WIDTH * IN_HEIGHT;
    localparam int NOUT       = OUT_WIDTH * OUT_HEIGHT;
    localparam int RW         = $clog2(NK) + 1;
    localparam int PW         = $clog2(NPIX) + 1;
    localparam int OW         = $clog2(NOUT) + 1;
    localparam int PIX_W      = 8 * IN_CHANNEL;

    if (NK < 1 || NPIX < 1 || NOUT < 1 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("conv_layer_seq: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE, LD_KERN, LD_BIAS, LD_COEFF, LD_SCALE, STREAM, DRAIN, DONE
    } state_t;

    state_t            state, ld_next;
    logic [RW-1:0]     rgn_idx, rgn_last;
    logic [31:0]       rgn_base;
    logic [PW-1:0]     pix_cnt;
    logic [OW-1:0]     out_cnt, out_cnt_nxt;
    logic              is_ld, is_coeff, w_xfer, s_rdy, s_xfer, wd_fire;
    logic              wr_en_p1;
    logic [31:0]       wr_addr_p1, wr_data_p1;
    logic              vld_p1;
    logic [PIX_W-1:0]  pix_p1;

    function automatic logic [OW-1:0] sat_inc(input logic [OW-1:0] c);
        return (c >= OW'(NOUT)) ? OW'(NOUT) : c + OW'(1);
    endfunction

    // COEFF and SCALE carry a 16-bit payload in the low half of the word.
    function automatic logic [31:0] coeff_word(input logic [31:0] w);
        return {16'b0, w[15:0]};
    endfunction

    always_comb begin
        rgn_base = 32'(KERNEL_BASE_ADDR);
        rgn_last = RW'(NK - 1);
        ld_next  = LD_BIAS;
        case (state)
            LD_BIAS:  begin rgn_base = 32'(BIAS_BASE);  rgn_last = RW'(OUT_CHANNEL - 1); ld_next = LD_COEFF; end
            LD_COEFF: begin rgn_base = 32'(COEFF_ADDR); rgn_last = '0; ld_next = LD_SCALE; end
            LD_SCALE: begin rgn_base = 32'(SCALE_ADDR); rgn_last = '0; ld_next = STREAM; end
            default:  ;
        endcase
    end

    assign is_ld       = state inside {LD_KERN, LD_BIAS, LD_COEFF, LD_SCALE};
    assign is_coeff    = (state == LD_COEFF) || (state == LD_SCALE);
    assign w_xfer      = bus.w_valid && is_ld;
    assign s_rdy       = (state == STREAM) && !bus.fifo_almost_full;
    assign s_xfer      = bus.s_valid && s_rdy;
    assign out_cnt_nxt = bus.conv_o_valid ? sat_inc(out_cnt) : out_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rgn_idx    <= '0;
            pix_cnt    <= '0;
            out_cnt    <= '0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            vld_p1     <= 1'b0;
            pix_p1     <= '0;
        end else begin
            // p0 -> p1: accepted word/pixel lands on the conv ports one cycle later
            wr_en_p1 <= w_xfer;
            vld_p1   <= s_xfer;
            if (w_xfer) begin
                wr_addr_p1 <= rgn_base + 32'(rgn_idx);
                wr_data_p1 <= is_coeff ? coeff_word(bus.w_data) : bus.w_data;
            end
            if (s_xfer)
                pix_p1 <= bus.s_data;
            if (state == STREAM || state == DRAIN)
                out_cnt <= out_cnt_nxt;

            case (state)
                IDLE: if (start) begin
                    state   <= LD_KERN;
                    rgn_idx <= '0;
                    pix_cnt <= '0;
                    out_cnt <= '0;
                end
                LD_KERN, LD_BIAS, LD_COEFF, LD_SCALE: if (w_xfer) begin
                    if (rgn_idx == rgn_last) begin
                        rgn_idx <= '0;
                        state   <= ld_next;
                    end else begin
                        rgn_idx <= rgn_idx + RW'(1);
                    end
                end
                STREAM: if (s_xfer) begin
                    pix_cnt <= pix_cnt + PW'(1);
                    if (pix_cnt == PW'(NPIX - 1))
                        state <= DRAIN;
                end
                DRAIN: if (out_cnt_nxt == OW'(NOUT) || wd_fire)
                    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_LAYER_SEQ_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0] wd_cnt;
    logic          err_q;

    // wd_cnt holds the number of cycles elapsed since the last conv output (or DRAIN entry).
    assign wd_fire = (state == DRAIN) && !bus.conv_o_valid && (wd_cnt >= WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != DRAIN)
                wd_cnt <= '0;
            else if (bus.conv_o_valid)
                wd_cnt <= WW'(1);
            else
                wd_cnt <= wd_cnt + WW'(1);
            if (wd_fire)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

    assign busy               = (state != IDLE);
    assign done               = (state == DONE);
    assign bus.w_ready        = is_ld;
    assign bus.s_ready        = s_rdy;
    assign bus.weight_wr_en   = wr_en_p1;
    assign bus.weight_wr_addr = wr_addr_p1;
    assign bus.weight_wr_data = wr_data_p1;
    assign bus.conv_i_valid   = vld_p1;
    assign bus.conv_i_data    = pix_p1;
endmodule
